qam_symbol_modulator: RTL
=========================

# qam_symbol_modulator

Parametrised QAM modulator that accepts symbols over a ready/valid interface, buffers them in a FIFO and holds each one for a fixed number of carrier samples. It supports QPSK, 16-QAM and 64-QAM, selectable at runtime. For each sample it produces the sum of the I-carrier and Q-carrier, each weighted by its constellation level. It sits between the symbol framer and the DAC interpolation chain, and replaces the fixed 16-QAM, per-sample-symbol modulator.

## Interface
- DATA_W, 18: width of the signed carrier inputs ipI and ipQ.
- OUT_W, 22: width of the signed output. Must be at least DATA_W+4.
- FIFO_DEPTH, 8: symbol FIFO depth. Must be a power of 2 and at least 2.
- SPS, 4: carrier samples per symbol. Must be at least 1.

Ports:
- ipClk  in  1  single clock for the whole block.
- ipReset  in  1  reset; asynchronous, active-low.
- ipMode  in  2  modulation mode: 00 = QPSK, 01 = 16-QAM, 10 = 64-QAM, 11 = reserved.
- ipSymbol  in  6  symbol bits; only the low 2k bits are used (k defined below).
- ipSymbolValid  in  1  symbol push request.
- opSymbolReady  out  1  high when the FIFO is not full.
- ipCarrierValid  in  1  ipI and ipQ are valid this cycle.
- ipI, ipQ  in  DATA_W  signed carrier samples.
- ipClearStatus  in  1  clears opUnderflow and opModeError.
- opModulated  out  OUT_W  signed modulated sample.
- opModulatedValid  out  1  opModulated is valid.
- opSymbolStart  out  1  marks the first output sample of each symbol period.
- opUnderflow  out  1  sticky flag: the FIFO was empty at a symbol boundary.
- opModeError  out  1  sticky flag: a symbol was loaded while ipMode = 11.
- opFillLevel  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- **FIFO push:** a symbol is written when ipSymbolValid && opSymbolReady. opSymbolReady = (fill != FIFO_DEPTH).
- **FIFO storage:** registered; there is no bypass. A symbol pushed in cycle T is poppable from T+1.
- **Symbol counter:** sc runs 0..SPS-1. It advances only on cycles with ipCarrierValid and wraps from SPS-1 to 0.
- **Symbol boundary:** a cycle with ipCarrierValid && sc == 0.
  - If the FIFO is non-empty: pop the head, and latch the symbol and the ipMode sampled in that cycle.
  - If the FIFO is empty: latch a zero-level symbol (both levels 0) and set opUnderflow.
- **Mode changes:** ipMode changes between boundaries are ignored until the next boundary.
- **Push and pop together:** a simultaneous push and pop is legal. The fill level is unchanged and the ordering is preserved.
- **Bits per axis:** k = 1 for QPSK, 2 for 16-QAM, 3 for 64-QAM.
  - The I axis uses bits [k-1:0]; the Q axis uses bits [2k-1:k].
- **Axis level mapping:** the top bit of each axis field is the sign (1 = negative).
  - The remaining k-1 bits form the magnitude index m, and level = ±(2m+1).
  - QPSK gives ±1, 16-QAM gives ±1/±3, 64-QAM gives ±1/±3/±5/±7.
  - Example, 16-QAM: 4'b0101 gives 3I+3Q; 4'b1010 gives -I-Q.
- **Reserved mode:** a symbol loaded with ipMode = 11 produces zero levels for its whole period and sets opModeError.
- **Arithmetic:**
  - Output = levelI*ipI + levelQ*ipQ, full precision, sign-extended to OUT_W. No saturation is needed.
  - Multiplication by 3, 5 and 7 is done by shift-add; no DSP multipliers are used.
- **Sticky flags:** cleared by ipClearStatus.
  - If a set event and a clear occur in the same cycle, set wins.
- **Reset (ipReset low, asynchronous):** all outputs are 0 and opSymbolReady is 0.
  - FIFO pointers and fill are cleared, sc = 0, the latched levels are 0, and the pipeline valid bits are cleared.
  - opSymbolReady returns to 1 on the first clock edge after release.
  - A reset asserted mid-symbol discards the current symbol and all buffered symbols.

## Timing
- **Latency:** fixed at 2 cycles from an ipCarrierValid cycle to its opModulatedValid.
  - Stage 1 registers the two weighted products.
  - Stage 2 registers the sum.
- **Boundary sample:** the sample on a boundary cycle already uses the newly latched symbol. The decode is combinational from the FIFO head.
- **Valid gaps:** gaps in ipCarrierValid propagate as gaps in opModulatedValid. There is no output backpressure.
- **opSymbolStart:** asserted with opModulatedValid, 2 cycles after each boundary cycle.
- **opUnderflow / opModeError:** set on the cycle after the offending boundary.
- **opFillLevel:** updates on the cycle after a push or pop.

## Test plan
1. **16-QAM sweep.** SPS=1, ipI=1000, ipQ=100, ipMode=01, symbols 0..15 preloaded.
   - Expect outputs 1100, 3100, -900, -2900, 1300, 3300, -700, -2700, 900, 2900, -1100, -3100, 700, 2700, -1300, -3300, each 2 cycles after its carrier sample.
2. **64-QAM extremes.**
   - Symbol 6'b011011 with ipI = ipQ = 131071: expect 1834994.
   - Symbol 6'b111111 with ipI = ipQ = -131072: expect 1835008.
   - Both results must be exact in 22 bits.
3. **QPSK hold and mode timing.** SPS=4, ipMode=00, symbols 2'b00 then 2'b11, ipI=ipQ=500.
   - Expect 1000 ×4, then -1000 ×4, with opSymbolStart on the 1st and 5th outputs.
   - Switching ipMode to 01 at sample 2 has no effect until sample 4.
4. **Underflow.** Empty FIFO, carrier running, SPS=4.
   - Expect four 0 outputs and opUnderflow = 1 from the cycle after the boundary.
   - The flag stays set until ipClearStatus; a symbol pushed mid-period is used only at the next boundary.
5. **Backpressure.** ipCarrierValid held low, 9 pushes offered.
   - Expect 8 accepted, opFillLevel = 8, opSymbolReady = 0, the 9th push held off.
   - On resuming the carrier, symbols are emitted in push order.
6. **Async reset.** Assert ipReset low mid-symbol between clock edges.
   - All outputs go to 0 immediately and opFillLevel = 0.
   - After release, the first boundary with an empty FIFO flags underflow.

Source files
------------

// File: rtl/qam_symbol_modulator.sv
// qam_symbol_modulator: buffered QPSK/16-QAM/64-QAM modulator. Symbols are
// queued in a small FIFO, each held for SPS carrier samples; every sample is
// levelI*ipI + levelQ*ipQ, computed with shift-add weights in a 2-stage pipe.

// Single-axis weight: x * (+/-mag), mag in {0,1,3,5,7}, built from shifts.
module qam_axis_weight #(
   parameter int DATA_W = 18
) (
   input  logic signed [DATA_W-1:0] ipX,
   input  logic                     ipNeg,
   input  logic [2:0]               ipMag,
   output logic signed [DATA_W+2:0] opProd
);
   localparam int PW = DATA_W + 3;

   logic signed [PW-1:0] x_ext;
   logic signed [PW-1:0] acc;

   // Sum the shifted copies selected by the magnitude bits, then apply sign.
   always_comb begin
      x_ext = PW'(ipX);
      acc   = '0;
      if (ipMag[0]) acc = acc + x_ext;
      if (ipMag[1]) acc = acc + (x_ext <<< 1);
      if (ipMag[2]) acc = acc + (x_ext <<< 2);
      opProd = ipNeg ? -acc : acc;
   end
endmodule

module qam_symbol_modulator #(
   parameter int DATA_W     = 18,
   parameter int OUT_W      = 22,
   parameter int FIFO_DEPTH = 8,
   parameter int SPS        = 4
) (
   input  logic                          ipClk,
   input  logic                          ipReset,
   input  logic [1:0]                    ipMode,
   input  logic [5:0]                    ipSymbol,
   input  logic                          ipSymbolValid,
   output logic                          opSymbolReady,
   input  logic                          ipCarrierValid,
   input  logic signed [DATA_W-1:0]      ipI,
   input  logic signed [DATA_W-1:0]      ipQ,
   input  logic                          ipClearStatus,
   output logic signed [OUT_W-1:0]       opModulated,
   output logic                          opModulatedValid,
   output logic                          opSymbolStart,
   output logic                          opUnderflow,
   output logic                          opModeError,
   output logic [$clog2(FIFO_DEPTH):0]   opFillLevel
);
   localparam int AW       = $clog2(FIFO_DEPTH);
   localparam int FW       = AW + 1;
   localparam int PW       = DATA_W + 3;
   localparam int SCW      = (SPS > 1) ? $clog2(SPS) : 1;
   localparam int STAGES   = 2;
   localparam int NUM_AXES = 2;

   // mag holds the odd level 2m+1 directly (0 for a zero-level symbol).
   typedef struct packed {
      logic       neg;
      logic [2:0] mag;
   } lvl_t;
   typedef lvl_t [NUM_AXES-1:0] lvl_pair_t;  // [0] = I, [1] = Q

   function automatic lvl_pair_t decode(input logic [5:0] sym, input logic [1:0] mode);
      lvl_pair_t r;
      r = '0;
      case (mode)
         2'b00: begin
            r[0] = {sym[0], 3'd1};
            r[1] = {sym[1], 3'd1};
         end
         2'b01: begin
            r[0] = {sym[1], 1'b0, sym[0], 1'b1};
            r[1] = {sym[3], 1'b0, sym[2], 1'b1};
         end
         2'b10: begin
            r[0] = {sym[2], sym[1:0], 1'b1};
            r[1] = {sym[5], sym[4:3], 1'b1};
         end
         default: r = '0;  // reserved mode: zero levels
      endcase
      return r;
   endfunction

   logic [5:0]      mem_q [FIFO_DEPTH];
   logic [5:0]      mem_d [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FW-1:0]   fill_q, fill_d;
   logic [SCW-1:0]  sc_q, sc_d;
   lvl_pair_t       lvl_q, lvl_d, lvl_cur;
   logic            rdy_en_q, rdy_en_d;
   logic            unf_q, unf_d, me_q, me_d;
   logic [STAGES:1] vld_pipe_q, vld_pipe_d;
   logic [STAGES:1] start_pipe_q, start_pipe_d;
   logic [NUM_AXES-1:0][PW-1:0] prod, prod_q, prod_d;
   logic signed [OUT_W-1:0]     sum_q, sum_d;
   logic [NUM_AXES-1:0][DATA_W-1:0] carrier;

   logic fifo_empty, fifo_full, ready, push, boundary, pop;

   // Handshake, boundary detection and the levels in force this cycle.
   always_comb begin
      fifo_empty = (fill_q == '0);
      fifo_full  = (fill_q == FW'(FIFO_DEPTH));
      ready      = rdy_en_q && !fifo_full;
      push       = ipSymbolValid && ready;
      boundary   = ipCarrierValid && (sc_q == '0);
      pop        = boundary && !fifo_empty;
      // The boundary sample already uses the new head symbol.
      lvl_cur    = lvl_q;
      if (boundary) lvl_cur = pop ? decode(mem_q[rd_ptr_q], ipMode) : '0;
      carrier    = {ipQ, ipI};
   end

   genvar g;
   generate
      for (g = 0; g < NUM_AXES; g++) begin : g_axis
         qam_axis_weight #(.DATA_W(DATA_W)) u_weight (
            .ipX    (carrier[g]),
            .ipNeg  (lvl_cur[g].neg),
            .ipMag  (lvl_cur[g].mag),
            .opProd (prod[g])
         );
      end
   endgenerate

   // Next-state for FIFO, symbol counter, latched levels, flags and pipeline.
   always_comb begin
      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      fill_d       = fill_q;
      sc_d         = sc_q;
      lvl_d        = lvl_q;
      rdy_en_d     = 1'b1;
      prod_d       = prod_q;
      sum_d        = sum_q;

      if (push) begin
         mem_d[wr_ptr_q] = ipSymbol;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   fill_d = fill_q + 1'b1;
         2'b01:   fill_d = fill_q - 1'b1;
         default: fill_d = fill_q;
      endcase

      if (boundary) lvl_d = lvl_cur;
      if (ipCarrierValid) sc_d = (sc_q == SCW'(SPS - 1)) ? '0 : sc_q + 1'b1;

      // Set wins over a same-cycle clear.
      unf_d = (boundary && fifo_empty) ? 1'b1 : (ipClearStatus ? 1'b0 : unf_q);
      me_d  = (pop && ipMode == 2'b11) ? 1'b1 : (ipClearStatus ? 1'b0 : me_q);

      vld_pipe_d   = {vld_pipe_q[STAGES-1:1], ipCarrierValid};
      start_pipe_d = {start_pipe_q[STAGES-1:1], boundary};
      if (ipCarrierValid) prod_d = prod;
      if (vld_pipe_q[1])
         sum_d = OUT_W'($signed(prod_q[0])) + OUT_W'($signed(prod_q[1]));
   end

   // State registers; reset discards any buffered or in-progress symbol.
   always_ff @(posedge ipClk or negedge ipReset) begin
      if (!ipReset) begin
         mem_q        <= '{default: '0};
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fill_q       <= '0;
         sc_q         <= '0;
         lvl_q        <= '0;
         rdy_en_q     <= 1'b0;
         unf_q        <= 1'b0;
         me_q         <= 1'b0;
         vld_pipe_q   <= '0;
         start_pipe_q <= '0;
         prod_q       <= '0;
         sum_q        <= '0;
      end else begin
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         fill_q       <= fill_d;
         sc_q         <= sc_d;
         lvl_q        <= lvl_d;
         rdy_en_q     <= rdy_en_d;
         unf_q        <= unf_d;
         me_q         <= me_d;
         vld_pipe_q   <= vld_pipe_d;
         start_pipe_q <= start_pipe_d;
         prod_q       <= prod_d;
         sum_q        <= sum_d;
      end
   end

   assign opSymbolReady    = ready;
   assign opModulated      = sum_q;
   assign opModulatedValid = vld_pipe_q[STAGES];
   assign opSymbolStart    = start_pipe_q[STAGES];
   assign opUnderflow      = unf_q;
   assign opModeError      = me_q;
   assign opFillLevel      = fill_q;
endmodule
